foy4_dec: RTL and testbench

FOY4_DEC -- requirements
Module: foy4_dec

---
 rtl/foy4_dec_if.sv | 27 ++
 rtl/foy4_dec.sv | 108 ++++++++++
 tb/tb_foy4_dec.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/foy4_dec_if.sv
// Symbol/decoder bus for foy4_dec: line-side inputs, level codes and decoded outputs.
// Everything except clk and reset travels over this interface.
interface foy4_dec_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [1:0]       sym;
  logic [1:0]       a;
  logic [1:0]       b;
  logic             d_out;
  logic             d_valid;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             sym_err;
  logic             cfg_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, sym, a, b,
    input  d_out, d_valid, byte_out, byte_valid, sym_err, cfg_err, err_cnt
  );

  modport slave (
    input  in_valid, sym, a, b,
    output d_out, d_valid, byte_out, byte_valid, sym_err, cfg_err, err_cnt
  );
endinterface

// File: rtl/foy4_dec.sv
// foy4 line decoder: maps symbols to levels, recovers transition-coded bits,
// assembles LSB-first bytes and counts illegal symbols with saturation.
module foy4_dec #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  foy4_dec_if.slave  bus
);
  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state_reg, state_next;
  logic             prev_level_reg, prev_level_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             d_out_reg, d_out_next;
  logic             d_valid_reg, d_valid_next;
  logic [7:0]       byte_out_reg, byte_out_next;
  logic             byte_valid_reg, byte_valid_next;
  logic             sym_err_reg, sym_err_next;
  logic             cfg_err_reg;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

  logic is_a, is_b, legal, level, dbit;

  always_comb begin
    state_next      = state_reg;
    prev_level_next = prev_level_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    d_out_next      = d_out_reg;
    d_valid_next    = 1'b0;
    byte_out_next   = byte_out_reg;
    byte_valid_next = 1'b0;
    sym_err_next    = 1'b0;
    err_cnt_next    = err_cnt_reg;

    // Code a takes priority so a transient a==b still yields a defined level.
    is_a  = (bus.sym == bus.a);
    is_b  = (bus.sym == bus.b);
    legal = is_a | is_b;
    level = ~is_a;
    dbit  = level ^ prev_level_reg;

    if (bus.in_valid) begin
      if (cfg_err_reg) begin
        state_next = HUNT;
      end else if (!legal) begin
        sym_err_next = 1'b1;
        if (err_cnt_reg != {CNT_W{1'b1}})
          err_cnt_next = err_cnt_reg + CNT_W'(1);
        if (state_reg == LOCK) begin
          bit_cnt_next = 3'd0;
          state_next   = HUNT;
        end
      end else if (state_reg == HUNT) begin
        prev_level_next = level;
        state_next      = LOCK;
      end else begin
        d_out_next              = dbit;
        d_valid_next            = 1'b1;
        prev_level_next         = level;
        shift_next[bit_cnt_reg] = dbit;
        bit_cnt_next            = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          byte_out_next   = {dbit, shift_reg[6:0]};
          byte_valid_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= LOCK;
      prev_level_reg <= 1'b0;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      d_out_reg      <= 1'b0;
      d_valid_reg    <= 1'b0;
      byte_out_reg   <= 8'd0;
      byte_valid_reg <= 1'b0;
      sym_err_reg    <= 1'b0;
      cfg_err_reg    <= 1'b0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      prev_level_reg <= prev_level_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      d_out_reg      <= d_out_next;
      d_valid_reg    <= d_valid_next;
      byte_out_reg   <= byte_out_next;
      byte_valid_reg <= byte_valid_next;
      sym_err_reg    <= sym_err_next;
      cfg_err_reg    <= (bus.a == bus.b);
      err_cnt_reg    <= err_cnt_next;
    end
  end

  assign bus.d_out      = d_out_reg;
  assign bus.d_valid    = d_valid_reg;
  assign bus.byte_out   = byte_out_reg;
  assign bus.byte_valid = byte_valid_reg;
  assign bus.sym_err    = sym_err_reg;
  assign bus.cfg_err    = cfg_err_reg;
  assign bus.err_cnt    = err_cnt_reg;
endmodule

// File: tb/tb_foy4_dec.sv
// Bench for foy4_dec: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a bit-list reference model.
module tb_foy4_dec;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  foy4_dec_if #(.CNT_W(CNT_W)) bus ();

  foy4_dec #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_cfg, m_lock, m_prev;
  int m_nbits;
  bit m_acc[8];
  int m_byte, m_err;
  bit e_d, e_dv, e_bv, e_se;

  int se_seen;
  bit tx_lvl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cfg = 0; m_lock = 1; m_prev = 0; m_nbits = 0;
    m_byte = 0; m_err = 0;
    e_d = 0; e_dv = 0; e_bv = 0; e_se = 0;
  endtask

  task automatic model_step();
    bit lvl, legal;
    int acc;
    e_dv = 0; e_bv = 0; e_se = 0;
    if (bus.in_valid === 1'b1) begin
      legal = (bus.sym == bus.a) || (bus.sym == bus.b);
      lvl   = (bus.sym == bus.a) ? 1'b0 : 1'b1;
      if (m_cfg) begin
        m_lock = 0;
      end else if (!legal) begin
        e_se  = 1;
        m_err = (m_err + 1 > CMAX) ? CMAX : m_err + 1;
        if (m_lock) m_nbits = 0;
        m_lock = 0;
      end else if (!m_lock) begin
        m_prev = lvl;
        m_lock = 1;
      end else begin
        e_d  = lvl ^ m_prev;
        e_dv = 1;
        m_prev = lvl;
        m_acc[m_nbits] = e_d;
        m_nbits++;
        if (m_nbits == 8) begin
          acc = 0;
          for (int i = 0; i < 8; i++) acc += int'(m_acc[i]) << i;
          m_byte  = acc;
          e_bv    = 1;
          m_nbits = 0;
        end
      end
    end
    m_cfg = (bus.a == bus.b);
  endtask

  task automatic check_outputs();
    check("d_valid",    bus.d_valid,    e_dv);
    check("d_out",      bus.d_out,      e_d);
    check("byte_valid", bus.byte_valid, e_bv);
    check("byte_out",   bus.byte_out,   m_byte);
    check("sym_err",    bus.sym_err,    e_se);
    check("cfg_err",    bus.cfg_err,    m_cfg);
    check("err_cnt",    bus.err_cnt,    m_err);
    check("bv_se_excl", bus.byte_valid & bus.sym_err, 0);
  endtask

  // One clock: model follows the inputs seen at the edge, outputs checked 1 ns later.
  task automatic cycle();
    @(posedge clk);
    if (reset === 1'b0) model_reset();
    else model_step();
    #1;
    if (bus.sym_err === 1'b1) se_seen++;
    if (bus.in_valid === 1'b1 && reset === 1'b1)
      $display("[TB] t=%0t sym=%b a=%b b=%b d_valid=%b d_out=%b byte_valid=%b byte=%02h sym_err=%b err_cnt=%0d",
               $time, bus.sym, bus.a, bus.b, bus.d_valid, bus.d_out, bus.byte_valid,
               bus.byte_out, bus.sym_err, bus.err_cnt);
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [1:0] s);
    bus.in_valid = v;
    bus.sym      = s;
    cycle();
  endtask

  task automatic send_bit(input bit d);
    tx_lvl = tx_lvl ^ d;
    drive(1'b1, tx_lvl ? bus.b : bus.a);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    bus.in_valid = 1'b0;
    cycle();
    reset  = 1'b1;
    tx_lvl = 1'b0;
  endtask

  initial begin
    bit exp_d[4];
    bit byte_bits[8];
    logic [1:0] s;
    int r;
    exp_d     = '{1'b0, 1'b1, 1'b0, 1'b1};
    byte_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    se_seen = 0;
    tx_lvl  = 1'b0;
    bus.in_valid = 1'b0; bus.sym = 2'b00; bus.a = 2'b01; bus.b = 2'b10;
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'($urandom);
      bus.sym = 2'($urandom); bus.a = 2'($urandom); bus.b = 2'($urandom);
      cycle();
    end
    bus.a = 2'b01; bus.b = 2'b10; bus.in_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 2'($urandom));
    check("rst_d_valid", bus.d_valid, 0);
    check("rst_err_cnt", bus.err_cnt, 0);

    // Basic decode from prev_level 0
    s = 2'b01; drive(1'b1, s); check("dec0", bus.d_out, exp_d[0]);
    s = 2'b10; drive(1'b1, s); check("dec1", bus.d_out, exp_d[1]);
    s = 2'b10; drive(1'b1, s); check("dec2", bus.d_out, exp_d[2]);
    s = 2'b01; drive(1'b1, s); check("dec3", bus.d_out, exp_d[3]);
    check("dec3_valid", bus.d_valid, 1);
    drive(1'b0, 2'b00);
    check("dec_idle_valid", bus.d_valid, 0);

    // Error and resync
    drive(1'b1, 2'b11);
    check("err_pulse", bus.sym_err, 1);
    check("err_cnt1",  bus.err_cnt, 1);
    drive(1'b1, 2'b10);
    check("relock_no_dv", bus.d_valid, 0);
    drive(1'b1, 2'b01);
    check("resync_d",  bus.d_out, 1);
    check("resync_dv", bus.d_valid, 1);

    // Partial byte discarded by reset, then a full byte with idle gaps
    pulse_reset();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      send_bit(byte_bits[i]);
      if (i == 7) begin
        check("byte_valid_8th", bus.byte_valid, 1);
        check("byte_4d", bus.byte_out, 8'h4D);
      end else begin
        check("byte_valid_early", bus.byte_valid, 0);
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive(1'b0, 2'($urandom));
    end
    drive(1'b0, 2'b00);
    check("byte_hold", bus.byte_out, 8'h4D);

    // Saturation
    pulse_reset();
    se_seen = 0;
    for (int i = 0; i < 260; i++) drive(1'b1, 2'b11);
    check("sat_cnt", bus.err_cnt, CMAX);
    check("sat_pulses", se_seen, 260);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00);
    check("sat_hold", bus.err_cnt, CMAX);

    // Configuration error
    pulse_reset();
    bus.a = 2'b10; bus.b = 2'b10;
    drive(1'b0, 2'b00);
    check("cfg_err_set", bus.cfg_err, 1);
    se_seen = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'($urandom));
      check("cfg_no_dv", bus.d_valid, 0);
    end
    check("cfg_no_se", se_seen, 0);
    bus.b = 2'b01;
    drive(1'b0, 2'b00);
    check("cfg_err_clr", bus.cfg_err, 0);
    drive(1'b1, 2'b01);
    check("cfg_relock", bus.d_valid, 0);
    drive(1'b1, 2'b10);
    check("cfg_dec_dv", bus.d_valid, 1);
    check("cfg_dec_d",  bus.d_out, 1);

    // Randomized traffic
    bus.a = 2'b01; bus.b = 2'b10;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        pulse_reset();
      end else if (r < 6) begin
        bus.a = 2'($urandom);
        bus.b = (r == 5) ? bus.a : 2'($urandom);
      end else if (r < 9) begin
        bus.a = 2'b01; bus.b = 2'b10;
      end
      r = int'($urandom_range(0, 5));
      s = (r < 2) ? bus.a : (r < 4) ? bus.b : 2'($urandom);
      drive(($urandom_range(0, 9) < 7), s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
